// File: rtl/idma_obi_mem_subordinate_pkg.sv
// Shared types and helpers for the OBI memory subordinate.
// The default request/response structs match the default parameter set
// (32-bit address, 32-bit data, 1-bit id). Instances with other widths
// pass their own struct types through the type parameters of the top.
package idma_obi_mem_subordinate_pkg;

   localparam int unsigned DefAddrWidth = 32;
   localparam int unsigned DefDataWidth = 32;
   localparam int unsigned DefIdWidth   = 1;

   typedef struct packed {
      logic [DefAddrWidth-1:0]   addr;
      logic                      we;
      logic [DefDataWidth/8-1:0] be;
      logic [DefDataWidth-1:0]   wdata;
      logic [DefIdWidth-1:0]     aid;
   } obi_a_chan_default_t;

   typedef struct packed {
      logic                a_req;
      obi_a_chan_default_t a;
      logic                r_ready;
   } obi_req_default_t;

   typedef struct packed {
      logic [DefDataWidth-1:0] rdata;
      logic [DefIdWidth-1:0]   rid;
      logic                    err;
   } obi_r_chan_default_t;

   typedef struct packed {
      logic                a_gnt;
      logic                r_valid;
      obi_r_chan_default_t r;
   } obi_rsp_default_t;

   // Index/pointer width that stays at least one bit for single-entry arrays.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/idma_obi_mem_subordinate_fifo.sv
// Response buffer: non-fall-through FIFO in the style of fifo_v3.
// Push while full and pop while empty are ignored; flush clears the pointers.
module idma_obi_mem_subordinate_fifo
   import idma_obi_mem_subordinate_pkg::*;
#(
   parameter int unsigned DEPTH   = 2,
   parameter type         dtype_t = logic
)(
   input  logic   clk_i,
   input  logic   rst_ni,
   input  logic   flush_i,
   output logic   full_o,
   output logic   empty_o,
   input  dtype_t data_i,
   input  logic   push_i,
   output dtype_t data_o,
   input  logic   pop_i
);

   localparam int unsigned PtrW = idx_width(DEPTH);
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [PtrW-1:0] r_wr_ptr;
   logic [PtrW-1:0] r_rd_ptr;
   logic [CntW-1:0] r_cnt;
   dtype_t          r_storage [DEPTH];
   logic            w_push;
   logic            w_pop;

   assign full_o  = (r_cnt == CntW'(DEPTH));
   assign empty_o = (r_cnt == '0);
   assign w_push  = push_i & ~full_o;
   assign w_pop   = pop_i & ~empty_o;
   assign data_o  = r_storage[r_rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap at DEPTH.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else if (flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == PtrW'(DEPTH - 1)) ? '0 : r_wr_ptr + PtrW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == PtrW'(DEPTH - 1)) ? '0 : r_rd_ptr + PtrW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CntW'(1);
            2'b01:   r_cnt <= r_cnt - CntW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Entry storage, cleared on reset so the head never shows stale data.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_storage[i] <= '0;
         end
      end else if (w_push) begin
         r_storage[r_wr_ptr] <= data_i;
      end
   end

endmodule

// File: rtl/idma_obi_mem_subordinate.sv
// OBI subordinate with a flat word-addressed register memory.
// Address phases are granted combinationally; responses are queued in a
// bounded in-order buffer and presented from its head until accepted.
module idma_obi_mem_subordinate
   import idma_obi_mem_subordinate_pkg::*;
#(
   parameter int unsigned AddrWidth      = DefAddrWidth,
   parameter int unsigned DataWidth      = DefDataWidth,
   parameter int unsigned IdWidth        = DefIdWidth,
   parameter int unsigned NumWords       = 1024,
   parameter int unsigned MaxOutstanding = 2,
   parameter type         obi_req_t      = obi_req_default_t,
   parameter type         obi_rsp_t      = obi_rsp_default_t
)(
   input  logic     clk_i,
   input  logic     rst_ni,
   input  obi_req_t obi_req_i,
   output obi_rsp_t obi_rsp_o,
   input  logic     gnt_stall_i
);

   localparam int unsigned NumBytes = DataWidth / 8;
   localparam int unsigned ByteOffW = $clog2(NumBytes);
   localparam int unsigned IdxW     = idx_width(NumWords);

   typedef struct packed {
      logic [DataWidth-1:0] rdata;
      logic [IdWidth-1:0]   rid;
      logic                 err;
   } rsp_entry_t;

   logic [DataWidth-1:0] r_mem [NumWords];

   logic                 w_full;
   logic                 w_empty;
   logic                 w_gnt;
   logic                 w_pop;
   logic                 w_in_range;
   logic [AddrWidth-1:0] w_word_addr;
   logic [IdxW-1:0]      w_idx;
   rsp_entry_t           w_push_entry;
   rsp_entry_t           w_head;

   assign w_word_addr = obi_req_i.a.addr >> ByteOffW;
   assign w_in_range  = (64'(w_word_addr) < 64'(NumWords));
   assign w_idx       = obi_req_i.a.addr[ByteOffW +: IdxW];

   // rst_ni is folded in so no grant is visible while reset is held.
   assign w_gnt = obi_req_i.a_req & ~w_full & ~gnt_stall_i & rst_ni;
   assign w_pop = ~w_empty & obi_req_i.r_ready;

   // Response entry for the access being granted; read data is taken at grant.
   always_comb begin
      w_push_entry     = '0;
      w_push_entry.rid = obi_req_i.a.aid;
      w_push_entry.err = ~w_in_range;
      if (w_in_range && !obi_req_i.a.we) begin
         w_push_entry.rdata = r_mem[w_idx];
      end
   end

   // Memory: cleared on reset, byte-masked write on an in-range granted write.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < NumWords; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_gnt && obi_req_i.a.we && w_in_range) begin
         for (int unsigned b = 0; b < NumBytes; b++) begin
            if (obi_req_i.a.be[b]) begin
               r_mem[w_idx][8*b +: 8] <= obi_req_i.a.wdata[8*b +: 8];
            end
         end
      end
   end

   idma_obi_mem_subordinate_fifo #(
      .DEPTH   (MaxOutstanding),
      .dtype_t (rsp_entry_t)
   ) i_rsp_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (1'b0),
      .full_o  (w_full),
      .empty_o (w_empty),
      .data_i  (w_push_entry),
      .push_i  (w_gnt),
      .data_o  (w_head),
      .pop_i   (w_pop)
   );

   // Response drive; the R channel reads zero whenever no response is valid.
   always_comb begin
      obi_rsp_o         = '0;
      obi_rsp_o.a_gnt   = w_gnt;
      obi_rsp_o.r_valid = ~w_empty;
      if (!w_empty) begin
         obi_rsp_o.r.rdata = w_head.rdata;
         obi_rsp_o.r.rid   = w_head.rid;
         obi_rsp_o.r.err   = w_head.err;
      end
   end

endmodule

// File: tb/tb_idma_obi_mem_subordinate.sv
// Scoreboard bench for idma_obi_mem_subordinate (default parameters).
module tb_idma_obi_mem_subordinate;
   import idma_obi_mem_subordinate_pkg::*;

   localparam int unsigned NUM_WORDS = 1024;
   localparam int unsigned MAX_OUT   = 2;

   typedef struct {
      logic [31:0] rdata;
      logic [0:0]  rid;
      logic        err;
   } exp_t;

   logic             clk_i;
   logic             rst_ni;
   logic             stall;
   obi_req_default_t req;
   obi_rsp_default_t rsp;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t q[$];
   logic [31:0] model_mem [NUM_WORDS];
   bit   rand_on;

   idma_obi_mem_subordinate #(
      .NumWords       (NUM_WORDS),
      .MaxOutstanding (MAX_OUT)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .obi_req_i   (req),
      .obi_rsp_o   (rsp),
      .gnt_stall_i (stall)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference behaviour of one granted access: returns the expected response
   // and applies any write to the model memory.
   function automatic exp_t model_access(input logic we, input logic [31:0] addr,
                                         input logic [3:0] be, input logic [31:0] wdata,
                                         input logic [0:0] aid);
      exp_t        e;
      int unsigned word;
      word    = addr / 4;
      e.rid   = aid;
      e.rdata = 32'h0;
      e.err   = 1'b0;
      if (word >= NUM_WORDS) begin
         e.err = 1'b1;
      end else if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) model_mem[word][8*b +: 8] = wdata[8*b +: 8];
         end
      end else begin
         e.rdata = model_mem[word];
      end
      return e;
   endfunction

   // Monitor: samples just before each rising edge, checks grant/valid against
   // the model occupancy, pops on handshake, pushes expectations on grant.
   logic        hold;
   logic [33:0] held_r;
   always begin
      exp_t e;
      logic exp_gnt, exp_valid;
      @(negedge clk_i);
      #3;
      if (!rst_ni) begin
         chk("rst_a_gnt", 64'(rsp.a_gnt), 64'(0));
         chk("rst_r_valid", 64'(rsp.r_valid), 64'(0));
         chk("rst_r", 64'({rsp.r.rdata, rsp.r.rid, rsp.r.err}), 64'(0));
         q.delete();
         for (int i = 0; i < NUM_WORDS; i++) model_mem[i] = 32'h0;
         hold = 1'b0;
      end else begin
         exp_valid = (q.size() != 0);
         exp_gnt   = req.a_req && !stall && (q.size() < MAX_OUT);
         chk("r_valid", 64'(rsp.r_valid), 64'(exp_valid));
         chk("a_gnt", 64'(rsp.a_gnt), 64'(exp_gnt));
         if (hold) begin
            chk("r_hold_valid", 64'(rsp.r_valid), 64'(1));
            chk("r_hold_stable", 64'({rsp.r.rdata, rsp.r.rid, rsp.r.err}), 64'(held_r));
         end
         if (rsp.r_valid && req.r_ready && q.size() != 0) begin
            e = q.pop_front();
            chk("rdata", 64'(rsp.r.rdata), 64'(e.rdata));
            chk("rid", 64'(rsp.r.rid), 64'(e.rid));
            chk("err", 64'(rsp.r.err), 64'(e.err));
         end
         hold   = rsp.r_valid && !req.r_ready;
         held_r = {rsp.r.rdata, rsp.r.rid, rsp.r.err};
         if (rsp.a_gnt) begin
            e = model_access(req.a.we, req.a.addr, req.a.be, req.a.wdata, req.a.aid);
            q.push_back(e);
         end
      end
   end

   // Present one address phase at a falling edge and hold it until granted.
   task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, input logic [0:0] aid);
      int n;
      bit got;
      @(negedge clk_i);
      req.a_req   = 1'b1;
      req.a.we    = we;
      req.a.addr  = addr;
      req.a.be    = be;
      req.a.wdata = wdata;
      req.a.aid   = aid;
      n   = 0;
      got = 0;
      while (!got && n < 200) begin
         #2;
         if (rsp.a_gnt) got = 1;
         else begin
            @(negedge clk_i);
            n++;
         end
      end
      if (!got) begin
         n_tests++;
         n_fail++;
         $display("FAIL gnt_timeout: no grant for addr %0h after %0d cycles", addr, n);
      end
      @(posedge clk_i);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk_i);
         req.a_req = 1'b0;
      end
   endtask

   initial begin
      int n;
      rst_ni      = 1'b0;
      stall       = 1'b0;
      rand_on     = 1'b0;
      hold        = 1'b0;
      held_r      = '0;
      req         = '0;
      req.a_req   = 1'b1;
      req.a.addr  = 32'h10;
      req.r_ready = 1'b1;
      repeat (3) @(negedge clk_i);
      req.a_req = 1'b0;
      #1 rst_ni = 1'b1;
      idle(2);

      // write then read back
      issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1);
      issue(1'b0, 32'h10, 4'hF, 32'h0, 1'b0);
      idle(2);

      // byte enables over cleared memory
      issue(1'b1, 32'h0, 4'h5, 32'h11223344, 1'b0);
      issue(1'b0, 32'h0, 4'hF, 32'h0, 1'b1);
      // zero byte-enable write leaves memory unchanged
      issue(1'b1, 32'h0, 4'h0, 32'hFFFFFFFF, 1'b1);
      issue(1'b0, 32'h3, 4'hF, 32'h0, 1'b0);
      idle(2);

      // out of range: error response, write must not alias onto word 0
      issue(1'b0, 32'h1000, 4'hF, 32'h0, 1'b1);
      issue(1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 1'b0);
      issue(1'b0, 32'h0, 4'hF, 32'h0, 1'b0);
      idle(2);

      // backpressure: two fill the buffer, third waits until r_ready rises
      req.r_ready = 1'b0;
      issue(1'b0, 32'h10, 4'hF, 32'h0, 1'b0);
      issue(1'b0, 32'h0, 4'hF, 32'h0, 1'b1);
      fork
         issue(1'b0, 32'h10, 4'hF, 32'h0, 1'b1);
         begin
            repeat (6) @(negedge clk_i);
            req.r_ready = 1'b1;
         end
      join
      idle(3);

      // grant stall for four cycles with a pending request
      stall = 1'b1;
      fork
         issue(1'b0, 32'h10, 4'hF, 32'h0, 1'b0);
         begin
            repeat (5) @(negedge clk_i);
            stall = 1'b0;
         end
      join
      idle(3);

      // reset with two responses pending
      issue(1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 1'b0);
      idle(2);
      req.r_ready = 1'b0;
      issue(1'b0, 32'h20, 4'hF, 32'h0, 1'b0);
      issue(1'b0, 32'h24, 4'hF, 32'h0, 1'b1);
      idle(2);
      @(negedge clk_i);
      #1 rst_ni = 1'b0;
      #1 chk("rst_async_r_valid", 64'(rsp.r_valid), 64'(0));
      repeat (2) @(negedge clk_i);
      #1 rst_ni = 1'b1;
      idle(3);
      req.r_ready = 1'b1;
      issue(1'b0, 32'h20, 4'hF, 32'h0, 1'b1);
      idle(3);

      // randomized traffic with random backpressure and stalls
      rand_on = 1'b1;
      fork
         begin
            for (int t = 0; t < 300; t++) begin
               logic [31:0] addr;
               if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h0000_1000;
               else addr = ($urandom_range(0, 31) * 4) | $urandom_range(0, 3);
               issue(1'($urandom_range(0, 1)), addr, 4'($urandom_range(0, 15)),
                     $urandom, 1'($urandom_range(0, 1)));
               if ($urandom_range(0, 3) == 0) idle(1);
            end
            rand_on = 1'b0;
         end
         begin
            while (rand_on) begin
               @(negedge clk_i);
               req.r_ready = ($urandom_range(0, 3) != 0);
               stall       = ($urandom_range(0, 4) == 0);
            end
         end
      join

      // drain outstanding responses
      stall       = 1'b0;
      req.r_ready = 1'b1;
      idle(1);
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      chk("drain_outstanding", 64'(q.size()), 64'(0));
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
